// File: rtl/sprite_blitter.sv
// Sprite blitter: walks a width x height sprite in ROM, drops colour-keyed and
// off-screen pixels, and hands the rest to a ready-gated pixel writer.
module sprite_blitter #(
   parameter int          SCREEN_W     = 240,
   parameter int          SCREEN_H     = 320,
   parameter logic [15:0] TRANSPARENT  = 16'hF81F,
   parameter int          READ_LATENCY = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  spriteId,
   input  logic [7:0]  xOrigin,
   input  logic [8:0]  yOrigin,
   input  logic [7:0]  width,
   input  logic [8:0]  height,
   output logic [3:0]  ROMId,
   output logic [15:0] ROMAddr,
   input  logic [15:0] ROMData,
   output logic        pixelWrite,
   input  logic        pixelReady,
   output logic [7:0]  pixelX,
   output logic [8:0]  pixelY,
   output logic [15:0] pixelData,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DRAW,
      ADVANCE,
      DONE
   } state_t;

   localparam logic [9:0] SCR_W     = 10'(SCREEN_W);
   localparam logic [9:0] SCR_H     = 10'(SCREEN_H);
   localparam logic [7:0] WAIT_LAST = 8'(READ_LATENCY - 1);

   state_t      state;
   state_t      state_nx;

   logic [3:0]  lat_id;
   logic [7:0]  lat_x;
   logic [8:0]  lat_y;
   logic [7:0]  lat_w;
   logic [8:0]  lat_h;
   logic [7:0]  col;
   logic [8:0]  row;
   logic [15:0] addr;
   logic [15:0] data_q;
   logic [7:0]  wait_cnt;

   logic [8:0]  scr_x;
   logic [9:0]  scr_y;
   logic        fetch_last;
   logic        off_screen;
   logic        skip;
   logic        last_col;
   logic        last_row;
   logic        empty_req;

   assign scr_x      = {1'b0, lat_x} + {1'b0, col};
   assign scr_y      = {1'b0, lat_y} + {1'b0, row};
   assign fetch_last = (wait_cnt == WAIT_LAST);
   assign off_screen = ({1'b0, scr_x} >= SCR_W) || (scr_y >= SCR_H);
   // The colour key is judged on the word arriving this cycle, not the old capture.
   assign skip       = (ROMData == TRANSPARENT) || off_screen;
   assign last_col   = (col == lat_w - 8'd1);
   assign last_row   = (row == lat_h - 9'd1);
   assign empty_req  = (width == 8'd0) || (height == 9'd0);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nx = empty_req ? DONE : FETCH;
            end
         end
         FETCH: begin
            if (fetch_last) begin
               state_nx = skip ? ADVANCE : DRAW;
            end
         end
         DRAW: begin
            if (pixelReady) begin
               state_nx = ADVANCE;
            end
         end
         ADVANCE: begin
            state_nx = (last_col && last_row) ? DONE : FETCH;
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lat_id   <= '0;
         lat_x    <= '0;
         lat_y    <= '0;
         lat_w    <= '0;
         lat_h    <= '0;
         col      <= '0;
         row      <= '0;
         addr     <= '0;
         data_q   <= '0;
         wait_cnt <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  lat_id   <= spriteId;
                  lat_x    <= xOrigin;
                  lat_y    <= yOrigin;
                  lat_w    <= width;
                  lat_h    <= height;
                  col      <= '0;
                  row      <= '0;
                  addr     <= '0;
                  wait_cnt <= '0;
               end
            end
            FETCH: begin
               if (fetch_last) begin
                  data_q   <= ROMData;
                  wait_cnt <= '0;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            ADVANCE: begin
               // Address is a running counter, so row*width+col never needs a multiplier.
               if (!(last_col && last_row)) begin
                  addr <= addr + 16'd1;
                  if (last_col) begin
                     col <= '0;
                     row <= row + 9'd1;
                  end else begin
                     col <= col + 8'd1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign ROMId      = lat_id;
   assign ROMAddr    = addr;
   assign pixelX     = scr_x[7:0];
   assign pixelY     = scr_y[8:0];
   assign pixelData  = data_q;
   assign pixelWrite = (state == DRAW);
   assign busy       = (state == FETCH) || (state == DRAW) || (state == ADVANCE);
   assign done       = (state == DONE);

endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter: a list-based model of each draw (expected writes,
// addresses, busy cycles) is checked against the DUT every cycle.
module tb_sprite_blitter;

   localparam int          L  = 2;
   localparam logic [15:0] TR = 16'hF81F;

   logic        clock = 0;
   logic        reset = 0;
   logic        start = 0;
   logic [3:0]  spriteId = 0;
   logic [7:0]  xOrigin = 0;
   logic [8:0]  yOrigin = 0;
   logic [7:0]  width = 0;
   logic [8:0]  height = 0;
   logic [3:0]  ROMId;
   logic [15:0] ROMAddr;
   logic [15:0] ROMData;
   logic        pixelWrite;
   logic        pixelReady = 1;
   logic [7:0]  pixelX;
   logic [8:0]  pixelY;
   logic [15:0] pixelData;
   logic        busy;
   logic        done;

   always #5 clock = ~clock;

   sprite_blitter dut (
      .clock(clock), .reset(reset), .start(start),
      .spriteId(spriteId), .xOrigin(xOrigin), .yOrigin(yOrigin),
      .width(width), .height(height),
      .ROMId(ROMId), .ROMAddr(ROMAddr), .ROMData(ROMData),
      .pixelWrite(pixelWrite), .pixelReady(pixelReady),
      .pixelX(pixelX), .pixelY(pixelY), .pixelData(pixelData),
      .busy(busy), .done(done)
   );

   logic [15:0] rom [16][256];
   logic [15:0] rom_q;
   always @(posedge clock) rom_q <= rom[ROMId][ROMAddr[7:0]];
   assign ROMData = rom_q;

   typedef struct packed {
      logic [7:0]  x;
      logic [8:0]  y;
      logic [15:0] d;
   } wr_t;

   wr_t         exp_w[$];
   logic [15:0] exp_a[$];
   int          errors = 0;
   int          checks = 0;
   int          ready_mode = 0;
   int          stall_left = 0;
   int          writes_seen = 0;
   logic [3:0]  cur_id = 0;
   bit          track = 0;
   bit          a_started = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   task automatic flag(input string name);
      checks++;
      errors++;
      $display("FAIL %s: event with nothing expected at %0t", name, $time);
   endtask

   // Ready driver, changed just after each rising edge.
   initial forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
         0: pixelReady = 1;
         1: pixelReady = 1'($urandom % 2);
         2: begin
            if (pixelWrite && stall_left > 0) begin
               pixelReady = 0;
               stall_left--;
            end else begin
               pixelReady = 1;
            end
         end
         default: pixelReady = 0;
      endcase
   end

   // Per-cycle compare against the model queues.
   logic        prev_pw = 0;
   logic        prev_rdy = 0;
   wr_t         prev_f;
   wr_t         cur_f;
   wr_t         e;
   logic [15:0] last_a = 0;
   initial forever begin
      @(negedge clock);
      if (!reset && track) begin
         cur_f = '{pixelX, pixelY, pixelData};
         if (prev_pw && !prev_rdy) begin
            chk("hold_write", 64'(pixelWrite), 64'(1));
            if (pixelWrite) chk("hold_fields", 64'(cur_f), 64'(prev_f));
         end
         if (pixelWrite && pixelReady) begin
            if (exp_w.size() == 0) begin
               flag("unexpected_write");
            end else begin
               e = exp_w.pop_front();
               chk("write", 64'(cur_f), 64'(e));
               writes_seen++;
            end
         end
         if (busy) begin
            chk("rom_id", 64'(ROMId), 64'(cur_id));
            if (!a_started || ROMAddr != last_a) begin
               if (exp_a.size() == 0) flag("unexpected_addr");
               else chk("rom_addr", 64'(ROMAddr), 64'(exp_a.pop_front()));
               a_started = 1;
               last_a = ROMAddr;
            end
         end
         prev_pw = pixelWrite;
         prev_rdy = pixelReady;
         prev_f = cur_f;
      end else begin
         prev_pw = 0;
         prev_rdy = 0;
      end
   end

   task automatic build(input int id, input int xo, input int yo, input int w,
                        input int h, output int cost, output int nexp);
      exp_w.delete();
      exp_a.delete();
      cost = 0;
      for (int r = 0; r < h; r++) begin
         for (int c = 0; c < w; c++) begin
            logic [15:0] a;
            logic [15:0] d;
            int x;
            int y;
            a = 16'(r * w + c);
            exp_a.push_back(a);
            d = rom[id][a[7:0]];
            x = xo + c;
            y = yo + r;
            if (d != TR && x < 240 && y < 320) begin
               exp_w.push_back('{8'(x), 9'(y), d});
               cost += L + 2;
            end else begin
               cost += L + 1;
            end
         end
      end
      nexp = exp_w.size();
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100; i++) begin
         @(posedge clock);
         #1;
         if (!busy && !done) return;
      end
      flag("idle_timeout");
   endtask

   task automatic launch(input int id, input int xo, input int yo, input int w, input int h);
      wait_idle();
      spriteId = 4'(id);
      xOrigin = 8'(xo);
      yOrigin = 9'(yo);
      width = 8'(w);
      height = 9'(h);
      cur_id = 4'(id);
      writes_seen = 0;
      a_started = 0;
      track = 1;
      start = 1;
      @(posedge clock);
      #1;
      start = 1'($urandom % 2);
      spriteId = 4'($urandom);
      xOrigin = 8'($urandom);
      yOrigin = 9'($urandom);
      width = 8'($urandom);
      height = 9'($urandom);
   endtask

   task automatic run_built(input int id, input int xo, input int yo, input int w,
                            input int h, input int exp_cycles, input int nexp);
      int cycles;
      int got;
      logic [15:0] fin;
      launch(id, xo, yo, w, h);
      cycles = 0;
      got = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clock);
         if (done) begin
            got = 1;
            break;
         end
         if (busy) cycles++;
      end
      start = 0;
      #1;
      chk("done_seen", 64'(got), 64'(1));
      if (exp_cycles >= 0) chk("busy_cycles", 64'(cycles), 64'(exp_cycles));
      chk("write_count", 64'(writes_seen), 64'(nexp));
      chk("addr_left", 64'(exp_a.size()), 64'(0));
      fin = (w * h == 0) ? 16'd0 : 16'(w * h - 1);
      chk("final_addr", 64'(ROMAddr), 64'(fin));
      chk("busy_at_done", 64'(busy), 64'(0));
      @(negedge clock);
      chk("done_pulse", 64'(done), 64'(0));
   endtask

   function automatic logic [63:0] all_outs();
      return 64'({ROMId, ROMAddr, pixelWrite, pixelX, pixelY, pixelData, busy, done});
   endfunction

   initial begin
      int cost;
      int nexp;
      int id, xo, yo, w, h, mode;
      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 256; j++)
            rom[i][j] = 16'(i * 256 + j);
      #1 reset = 1;
      #1 chk("reset_async", all_outs(), 64'(0));
      repeat (3) @(negedge clock);
      chk("reset_hold", all_outs(), 64'(0));
      reset = 0;

      // 2x2 opaque sprite
      rom[3][0] = 16'd1; rom[3][1] = 16'd2; rom[3][2] = 16'd3; rom[3][3] = 16'd4;
      build(3, 10, 20, 2, 2, cost, nexp);
      chk("model_2x2_n", 64'(nexp), 64'(4));
      chk("model_2x2_cost", 64'(cost), 64'(16));
      chk("model_2x2_last", 64'(exp_w[3]), 64'({8'd11, 9'd21, 16'd4}));
      run_built(3, 10, 20, 2, 2, cost, nexp);

      // transparent middle pixel
      rom[5][0] = 16'h1111; rom[5][1] = TR; rom[5][2] = 16'h2222;
      build(5, 0, 0, 3, 1, cost, nexp);
      chk("model_key_n", 64'(nexp), 64'(2));
      chk("model_key_2nd", 64'(exp_w[1]), 64'({8'd2, 9'd0, 16'h2222}));
      chk("model_key_cost", 64'(cost), 64'(11));
      run_built(5, 0, 0, 3, 1, cost, nexp);

      // bottom-right corner clip
      rom[6][0] = 16'hAAAA; rom[6][1] = 16'hBBBB; rom[6][2] = 16'hCCCC; rom[6][3] = 16'hDDDD;
      build(6, 239, 319, 2, 2, cost, nexp);
      chk("model_clip_n", 64'(nexp), 64'(1));
      chk("model_clip_w", 64'(exp_w[0]), 64'({8'd239, 9'd319, 16'hAAAA}));
      chk("model_clip_a", 64'(exp_a.size()), 64'(4));
      run_built(6, 239, 319, 2, 2, cost, nexp);

      // 5-cycle stall in DRAW
      rom[7][0] = 16'h1234;
      build(7, 5, 5, 1, 1, cost, nexp);
      ready_mode = 2;
      stall_left = 5;
      run_built(7, 5, 5, 1, 1, cost + 5, nexp);
      ready_mode = 0;

      // zero width
      build(2, 0, 0, 0, 3, cost, nexp);
      chk("model_empty_cost", 64'(cost), 64'(0));
      run_built(2, 0, 0, 0, 3, cost, nexp);

      // reset while a pixel is pending
      build(7, 5, 5, 1, 1, cost, nexp);
      ready_mode = 3;
      launch(7, 5, 5, 1, 1);
      start = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (pixelWrite) break;
      end
      chk("reached_draw", 64'(pixelWrite), 64'(1));
      track = 0;
      #2 reset = 1;
      #1 chk("mid_reset_outs", all_outs(), 64'(0));
      ready_mode = 0;
      @(negedge clock);
      chk("mid_reset_hold", all_outs(), 64'(0));
      reset = 0;
      build(3, 10, 20, 2, 2, cost, nexp);
      run_built(3, 10, 20, 2, 2, cost, nexp);

      for (int j = 0; j < 40; j++) begin
         id = int'($urandom % 16);
         w = ($urandom % 8 == 0) ? 0 : int'($urandom_range(1, 9));
         h = ($urandom % 8 == 0) ? 0 : int'($urandom_range(1, 7));
         xo = ($urandom % 2 == 1) ? int'($urandom_range(228, 255)) : int'($urandom % 256);
         yo = ($urandom % 2 == 1) ? int'($urandom_range(310, 511)) : int'($urandom % 512);
         mode = int'($urandom % 2);
         for (int a = 0; a < w * h; a++)
            rom[id][a] = ($urandom % 4 == 0) ? TR : 16'($urandom);
         build(id, xo, yo, w, h, cost, nexp);
         ready_mode = mode;
         run_built(id, xo, yo, w, h, (mode == 0) ? cost : -1, nexp);
      end
      ready_mode = 0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
